dpram_port_arbiter: RTL and testbench

Shares the 256×16 single-clock true dual-port RAM between `NREQ` independent requesters. Each cycle it grants up to two requests round-robin and maps them onto RAM ports A and B. It prevents same-address write collisions across the two ports and returns read data one cycle after grant. After reset it optionally sweeps the RAM to zero before accepting traffic.

---
 rtl/dpram_arb_pkg.sv | 11 +
 rtl/rr_pick2.sv | 37 +++
 rtl/dpram_port_arbiter.sv | 103 ++++++++++
 tb/tb_dpram_port_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared state, read-tag type and default widths for dpram_port_arbiter
package dpram_arb_pkg;
   localparam int DEF_AW = 8;
   localparam int DEF_DW = 16;
   localparam int IDX_W = 3;
   typedef enum logic {CLEAR, RUN} arb_state_t;
   typedef struct packed {
      logic valid;
      logic [IDX_W-1:0] idx;
   } rd_tag_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational round-robin picker of up to two mutually non-conflicting winners
//   valid_i    pending requests      ptr_i     first requester to scan
//   conflict_i [i][j]=1 if i and j may not share a cycle
//   w0_o/v0_o  first winner (port A)  w1_o/v1_o second winner (port B)
module rr_pick2 #(
   parameter int N = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid_i,
   input  logic [IW-1:0] ptr_i,
   input  logic [N-1:0]  conflict_i [N],
   output logic [IW-1:0] w0_o,
   output logic          v0_o,
   output logic [IW-1:0] w1_o,
   output logic          v1_o
);
   logic [IW-1:0] ord [N];
   for (genvar k = 0; k < N; k++) begin : g_ord
      assign ord[k] = IW'((int'(ptr_i) + k) % N);
   end
   always_comb begin
      v0_o = 1'b0;
      v1_o = 1'b0;
      w0_o = '0;
      w1_o = '0;
      for (int k = 0; k < N; k++)
         if (valid_i[ord[k]]) begin
            if (!v0_o) begin
               v0_o = 1'b1;
               w0_o = ord[k];
            end else if (!v1_o && !conflict_i[w0_o][ord[k]]) begin
               v1_o = 1'b1;
               w1_o = ord[k];
            end
         end
   end
endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares a true dual-port RAM between NREQ requesters, two grants per cycle
//   req_*      requester side, packed per requester; req_ready is the same-cycle grant
//   rsp_*      read data one cycle after grant
//   ram_*      RAM ports A/B plus output-register enable
//   clear_done high once the post-reset zeroing sweep has finished
module dpram_port_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [NREQ*DW-1:0] rsp_rdata,
   output logic               ram_ena,
   output logic [AW-1:0]      ram_addr_a,
   output logic [DW-1:0]      ram_data_a,
   output logic               ram_we_a,
   input  logic [DW-1:0]      ram_q_a,
   output logic [AW-1:0]      ram_addr_b,
   output logic [DW-1:0]      ram_data_b,
   output logic               ram_we_b,
   input  logic [DW-1:0]      ram_q_b,
   output logic               clear_done
);
   localparam int IW = $clog2(NREQ);
   localparam logic [AW-1:0] LAST_PAIR = {{(AW-1){1'b1}}, 1'b0};
   arb_state_t state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d, w0, w1, last;
   rd_tag_t tag_a_q, tag_a_d, tag_b_q, tag_b_d;
   logic clear_done_q, v0, v1, run, clr, rd_a, rd_b;
   logic [AW-1:0] addr [NREQ];
   logic [DW-1:0] wdata [NREQ];
   logic [NREQ-1:0] conf [NREQ];
   for (genvar i = 0; i < NREQ; i++) begin : g_req
      assign addr[i] = req_addr[i*AW +: AW];
      assign wdata[i] = req_wdata[i*DW +: DW];
      for (genvar j = 0; j < NREQ; j++) begin : g_conf
         assign conf[i][j] = addr[i] == addr[j] && (req_we[i] || req_we[j]);
      end
      assign req_ready[i] = run && ((v0 && w0 == IW'(i)) || (v1 && w1 == IW'(i)));
      // rst masks responses so a read in flight across reset is dropped
      assign rsp_valid[i] = !rst && ((tag_a_q.valid && tag_a_q.idx == IDX_W'(i)) ||
                                     (tag_b_q.valid && tag_b_q.idx == IDX_W'(i)));
      assign rsp_rdata[i*DW +: DW] = (tag_a_q.valid && tag_a_q.idx == IDX_W'(i)) ? ram_q_a :
                                     (tag_b_q.valid && tag_b_q.idx == IDX_W'(i)) ? ram_q_b : '0;
   end
   rr_pick2 #(.N(NREQ)) u_pick (
      .valid_i   (req_valid),
      .ptr_i     (rr_ptr_q),
      .conflict_i(conf),
      .w0_o      (w0),
      .v0_o      (v0),
      .w1_o      (w1),
      .v1_o      (v1)
   );
   assign run = !rst && state_q == RUN;
   assign clr = !rst && state_q == CLEAR;
   assign rd_a = run && v0 && !req_we[w0];
   assign rd_b = run && v1 && !req_we[w1];
   assign last = v1 ? w1 : w0;
   assign ram_ena = rd_a || rd_b;
   assign ram_we_a = clr || (run && v0 && req_we[w0]);
   assign ram_we_b = clr || (run && v1 && req_we[w1]);
   assign ram_addr_a = clr ? clr_addr_q : (run && v0) ? addr[w0] : '0;
   assign ram_addr_b = clr ? clr_addr_q + AW'(1) : (run && v1) ? addr[w1] : '0;
   assign ram_data_a = (run && v0) ? wdata[w0] : '0;
   assign ram_data_b = (run && v1) ? wdata[w1] : '0;
   assign clear_done = clear_done_q;
   always_comb begin
      state_d = (state_q == CLEAR && clr_addr_q == LAST_PAIR) ? RUN : state_q;
      clr_addr_d = state_q == CLEAR ? clr_addr_q + AW'(2) : clr_addr_q;
      rr_ptr_d = !(run && v0) ? rr_ptr_q : last == IW'(NREQ-1) ? '0 : last + IW'(1);
      tag_a_d = {rd_a, IDX_W'(w0)};
      tag_b_d = {rd_b, IDX_W'(w1)};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
         clr_addr_q <= '0;
         rr_ptr_q <= '0;
         tag_a_q <= '0;
         tag_b_q <= '0;
         clear_done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_addr_q <= clr_addr_d;
         rr_ptr_q <= rr_ptr_d;
         tag_a_q <= tag_a_d;
         tag_b_q <= tag_b_d;
         clear_done_q <= state_d == RUN;
      end
   end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed-vector bench with a behavioural 256x16 dual-port RAM
module tb_dpram_port_arbiter;
   logic clk = 1'b0, rst = 1'b1, prefill = 1'b1;
   logic [3:0] req_valid = '1, req_ready, req_we = '0, rsp_valid;
   logic [31:0] req_addr = '0;
   logic [63:0] req_wdata = '0, rsp_rdata;
   logic ram_ena, ram_we_a, ram_we_b, clear_done;
   logic [7:0] ram_addr_a, ram_addr_b;
   logic [15:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
   logic [15:0] mem [256];
   int n_tests = 0, n_fail = 0;
   int n, rdy_bad, rot_bad, lag_bad;
   int cnt [4];
   logic [3:0] prev_rdy;
   always #5 clk = ~clk;
   dpram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .ram_ena(ram_ena),
      .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a), .ram_q_a(ram_q_a),
      .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b),
      .clear_done(clear_done)
   );
   always @(posedge clk) begin
      if (prefill) begin
         for (int k = 0; k < 256; k++) mem[k] <= 16'hDEAD;
      end else begin
         if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
         if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
         if (ram_ena) begin
            ram_q_a <= mem[ram_addr_a];
            ram_q_b <= mem[ram_addr_b];
         end
      end
   end
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [15:0] d);
      req_valid[i] = 1'b1;
      req_we[i] = we;
      req_addr[i*8 +: 8] = a;
      req_wdata[i*16 +: 16] = d;
   endtask
   task automatic drop(input int i);
      req_valid[i] = 1'b0;
   endtask
   function automatic logic [15:0] rd(input int i);
      return rsp_rdata[i*16 +: 16];
   endfunction
   task automatic wait_clear(output int cycles, output int bad);
      cycles = 0;
      bad = 0;
      while (cycles < 300 && !clear_done) begin
         if (req_ready != 4'b0) bad++;
         cycles++;
         @(negedge clk);
      end
   endtask
   initial begin
      step();
      prefill = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 'b0);
      chk("rst_rsp", 32'(rsp_valid), 'b0);
      chk("rst_we", 32'({ram_we_b, ram_we_a}), 'b0);
      chk("rst_ena", 32'(ram_ena), 'b0);
      chk("rst_done", 32'(clear_done), 'b0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("clr0_addr_a", 32'(ram_addr_a), 'h00);
      chk("clr0_addr_b", 32'(ram_addr_b), 'h01);
      chk("clr0_we", 32'({ram_we_b, ram_we_a}), 'b11);
      wait_clear(n, rdy_bad);
      req_valid = '0;
      chk("clr_len", n, 128);
      chk("clr_ready", rdy_bad, 0);
      step();
      set_req(0, 0, 8'h00, 0);
      set_req(1, 0, 8'h7F, 0);
      set_req(2, 0, 8'hFF, 0);
      @(negedge clk);
      chk("clr_rd_rdy", 32'(req_ready), 'b0011);
      step();
      drop(0);
      drop(1);
      @(negedge clk);
      chk("clr_rd_vld", 32'(rsp_valid), 'b0011);
      chk("rd_00", 32'(rd(0)), 'h0);
      chk("rd_7f", 32'(rd(1)), 'h0);
      chk("req2_rdy", 32'(req_ready), 'b0100);
      step();
      drop(2);
      set_req(3, 1, 8'h20, 16'h1234);
      @(negedge clk);
      chk("rd_ff_vld", 32'(rsp_valid), 'b0100);
      chk("rd_ff", 32'(rd(2)), 'h0);
      chk("prewr_rdy", 32'(req_ready), 'b1000);
      chk("prewr_we", 32'({ram_we_b, ram_we_a}), 'b01);
      step();
      drop(3);
      set_req(0, 1, 8'h10, 16'hBEEF);
      @(negedge clk);
      chk("wr_no_rsp", 32'(rsp_valid), 'b0);
      chk("beef_rdy", 32'(req_ready), 'b0001);
      chk("wr_ena", 32'(ram_ena), 'b0);
      step();
      set_req(0, 0, 8'h10, 0);
      set_req(1, 0, 8'h20, 0);
      @(negedge clk);
      chk("dual_rdy", 32'(req_ready), 'b0011);
      chk("dual_ena", 32'(ram_ena), 'b1);
      step();
      drop(0);
      drop(1);
      set_req(3, 0, 8'h10, 0);
      @(negedge clk);
      chk("dual_vld", 32'(rsp_valid), 'b0011);
      chk("dual_rd0", 32'(rd(0)), 'hBEEF);
      chk("dual_rd1", 32'(rd(1)), 'h1234);
      chk("rd3_rdy", 32'(req_ready), 'b1000);
      step();
      drop(3);
      set_req(0, 1, 8'h05, 16'hAAAA);
      set_req(1, 1, 8'h05, 16'h5555);
      set_req(2, 0, 8'h06, 0);
      @(negedge clk);
      chk("rd3_vld", 32'(rsp_valid), 'b1000);
      chk("rd3", 32'(rd(3)), 'hBEEF);
      chk("cfl_rdy", 32'(req_ready), 'b0101);
      step();
      drop(0);
      drop(2);
      @(negedge clk);
      chk("cfl_rdy2", 32'(req_ready), 'b0010);
      chk("cfl_rsp", 32'(rsp_valid), 'b0100);
      chk("cfl_rd6", 32'(rd(2)), 'h0);
      step();
      drop(1);
      set_req(2, 0, 8'h05, 0);
      @(negedge clk);
      chk("cfl_rd_rdy", 32'(req_ready), 'b0100);
      step();
      drop(2);
      set_req(3, 0, 8'h40, 0);
      @(negedge clk);
      chk("cfl_final_vld", 32'(rsp_valid), 'b0100);
      chk("cfl_final", 32'(rd(2)), 'h5555);
      chk("ptr0_rdy", 32'(req_ready), 'b1000);
      step();
      for (int i = 0; i < 4; i++) set_req(i, 0, 8'(8'h40 + i), 0);
      rot_bad = 0;
      lag_bad = 0;
      prev_rdy = 4'b1000;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready !== ((c % 2) != 0 ? 4'b1100 : 4'b0011)) rot_bad++;
         if (rsp_valid !== prev_rdy) lag_bad++;
         prev_rdy = req_ready;
         for (int i = 0; i < 4; i++) cnt[i] += int'(req_ready[i]);
         step();
      end
      req_valid = '0;
      chk("fair_rot", rot_bad, 0);
      chk("fair_lag", lag_bad, 0);
      for (int i = 0; i < 4; i++) chk($sformatf("fair_cnt%0d", i), cnt[i], 10);
      set_req(0, 0, 8'h10, 0);
      @(negedge clk);
      chk("mid_rdy", 32'(req_ready), 'b0001);
      step();
      drop(0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_vld1", 32'(rsp_valid), 'b0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_vld2", 32'(rsp_valid), 'b0);
      chk("mid_addr_a", 32'(ram_addr_a), 'h00);
      chk("mid_addr_b", 32'(ram_addr_b), 'h01);
      chk("mid_we", 32'({ram_we_b, ram_we_a}), 'b11);
      chk("mid_done", 32'(clear_done), 'b0);
      wait_clear(n, rdy_bad);
      chk("mid_clr_len", n, 128);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
